rr_arb_8: RTL

Round-robin arbiter sharing one downstream resource among 2**widthi requesters (8 by default).
- Issues one registered one-hot grant plus its binary index.
- Holds the grant until the owner signals done, drops its request, or exceeds a hold limit.
- Sits in front of the registered one-hot decode path; grant_idx can drive a decoder select directly.

---
 rtl/rr_arb_8_pkg.sv | 22 ++
 rtl/rr_arb_8_pick.sv | 35 +++
 rtl/rr_arb_8.sv | 118 +++++++++++
 3 files changed

// File: rtl/rr_arb_8_pkg.sv
// Shared definitions for the rr_arb_8 round-robin arbiter.
//   state_e     : arbiter FSM states (IDLE / BUSY)
//   rel_cause_e : why a grant was released (debug / coverage)
//   WIDTHI_DEF, MAX_HOLD_DEF : default parameter values
package rr_arb_8_pkg;

  localparam int unsigned WIDTHI_DEF   = 3;
  localparam int unsigned MAX_HOLD_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    REL_NONE    = 2'd0,
    REL_DONE    = 2'd1,
    REL_DROP    = 2'd2,
    REL_TIMEOUT = 2'd3
  } rel_cause_e;

endpackage

// File: rtl/rr_arb_8_pick.sv
// Combinational round-robin pick.
//   req  : request vector, one bit per requester
//   ptr  : highest-priority requester index
//   pick : first requester with req set, searching ptr, ptr+1, ... (mod N)
//   any  : at least one request is set
module rr_pick #(
  parameter int unsigned widthi = 3
) (
  input  logic [(1 << widthi)-1:0] req,
  input  logic [widthi-1:0]        ptr,
  output logic [widthi-1:0]        pick,
  output logic                     any
);

  localparam int unsigned N = 1 << widthi;

  logic             found;
  logic [widthi-1:0] idx;

  // Index arithmetic is widthi bits wide, so ptr+i wraps modulo N for free.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = ptr + widthi'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/rr_arb_8.sv
// Round-robin arbiter for 2**widthi requesters sharing one resource.
//   clk, rst    : clock, synchronous active-high reset
//   enable      : active-low; 1 blocks new grants, an active grant continues
//   req         : level-sensitive request vector
//   done        : owner releases the grant
//   grant       : registered one-hot grant (zero when idle)
//   grant_idx   : registered binary index of owner (zero when idle)
//   grant_valid : registered, high while a grant is active
//   timeout     : registered one-cycle pulse on forced release at hold limit
// Every release passes through IDLE, giving one dead cycle between grants.
module rr_arb_8
  import rr_arb_8_pkg::*;
#(
  parameter int unsigned widthi   = WIDTHI_DEF,
  parameter int unsigned max_hold = MAX_HOLD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [(1 << widthi)-1:0] req,
  input  logic                     done,
  output logic [(1 << widthi)-1:0] grant,
  output logic [widthi-1:0]        grant_idx,
  output logic                     grant_valid,
  output logic                     timeout
);

  localparam int unsigned N  = 1 << widthi;
  localparam int unsigned HW = $clog2(max_hold);
  localparam logic [HW-1:0] HOLD_LAST = HW'(max_hold - 1);

  state_e            state_q, state_d;
  logic [widthi-1:0] ptr_q, ptr_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [widthi-1:0] grant_idx_q, grant_idx_d;
  logic              grant_valid_q, grant_valid_d;
  logic              timeout_q, timeout_d;

  logic [widthi-1:0] pick;
  logic              any;
  rel_cause_e        cause;

  rr_pick #(.widthi(widthi)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    cause         = REL_NONE;

    case (state_q)
      IDLE: begin
        if (!enable && any) begin
          state_d       = BUSY;
          grant_idx_d   = pick;
          grant_d       = {{(N-1){1'b0}}, 1'b1} << pick;
          grant_valid_d = 1'b1;
          hold_cnt_d    = '0;
        end
      end
      BUSY: begin
        // Priority order decides the cause; only a pure limit hit pulses timeout.
        if (done)                       cause = REL_DONE;
        else if (!req[grant_idx_q])     cause = REL_DROP;
        else if (hold_cnt_q == HOLD_LAST) cause = REL_TIMEOUT;

        if (cause != REL_NONE) begin
          state_d       = IDLE;
          ptr_d         = grant_idx_q + widthi'(1);
          hold_cnt_d    = '0;
          grant_d       = '0;
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
          timeout_d     = (cause == REL_TIMEOUT);
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule
